// File: rtl/alu_result_queue.sv
// In-order result queue between the ALU and write-back: circular buffer with
// occupancy count, stored zero flag, flush, and youngest-match forwarding.
module alu_result_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_y,
   input  logic                     in_cout,
   input  logic [4:0]               in_wa,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_y,
   output logic                     out_cout,
   output logic                     out_zero,
   output logic [4:0]               out_wa,
   input  logic                     flush,
   input  logic [4:0]               fwd_ra,
   output logic                     fwd_hit,
   output logic [31:0]              fwd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]   y_mem    [DEPTH];
   logic          cout_mem [DEPTH];
   logic          zero_mem [DEPTH];
   logic [4:0]    wa_mem   [DEPTH];

   logic [AW-1:0] rp;
   logic [AW-1:0] wp;
   logic [AW-1:0] fidx;
   logic          push;
   logic          pop;

   assign in_ready  = (count != (AW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_y    = y_mem[rp];
   assign out_cout = cout_mem[rp];
   assign out_zero = zero_mem[rp];
   assign out_wa   = wa_mem[rp];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else if (flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         y_mem[wp]    <= in_y;
         cout_mem[wp] <= in_cout;
         zero_mem[wp] <= (in_y == '0);
         wa_mem[wp]   <= in_wa;
      end
   end

   // Walk entries oldest to youngest so the last match (youngest) wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fidx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fidx = rp + AW'(i);
         if (((AW+1)'(i) < count) && (wa_mem[fidx] == fwd_ra) && (fwd_ra != '0)) begin
            fwd_hit  = 1'b1;
            fwd_data = y_mem[fidx];
         end
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: queue-based reference model checked
// every cycle on the falling edge, plus hand-computed literal expectations.
module tb_alu_result_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_y = '0;
   logic        in_cout = 1'b0;
   logic [4:0]  in_wa = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_y;
   logic        out_cout;
   logic        out_zero;
   logic [4:0]  out_wa;
   logic        flush = 1'b0;
   logic [4:0]  fwd_ra = '0;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;
   bit model_ok = 1'b0;

   typedef struct {
      logic [31:0] y;
      logic        cout;
      logic [4:0]  wa;
   } entry_t;

   entry_t q[$];

   alu_result_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_cout(in_cout), .in_wa(in_wa),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_cout(out_cout),
      .out_zero(out_zero), .out_wa(out_wa), .flush(flush), .fwd_ra(fwd_ra),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: plain FIFO of entries updated on each rising edge.
   always @(posedge clk) begin
      if (!reset || flush) begin
         q.delete();
      end else begin
         bit do_pop;
         bit do_push;
         entry_t e;
         do_pop  = (q.size() != 0) && out_ready;
         do_push = in_valid && (q.size() != DEPTH);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.y = in_y; e.cout = in_cout; e.wa = in_wa;
            q.push_back(e);
         end
      end
      if (!reset) model_ok = 1'b1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         bit          hit;
         logic [31:0] data;
         check("count", 32'(count), 32'(q.size()));
         check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
         check("out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check("out_y", out_y, q[0].y);
            check("out_cout", 32'(out_cout), 32'(q[0].cout));
            check("out_zero", 32'(out_zero), 32'(q[0].y == 0));
            check("out_wa", 32'(out_wa), 32'(q[0].wa));
         end
         hit = 1'b0;
         data = '0;
         if (fwd_ra != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (!hit && q[i].wa == fwd_ra) begin
                  hit = 1'b1;
                  data = q[i].y;
               end
            end
         end
         check("fwd_hit", 32'(fwd_hit), 32'(hit));
         check("fwd_data", fwd_data, data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] y, input logic c, input logic [4:0] wa);
      in_valid = v; in_y = y; in_cout = c; in_wa = wa;
   endtask

   task automatic push1(input logic [31:0] y, input logic c, input logic [4:0] wa);
      set_in(1'b1, y, c, wa);
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      int          expv;
      int          budget;
      bit          accepted;
      reset = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
      check("rst_fwd_data", fwd_data, 32'd0);

      push1(32'd8, 1'b0, 5'd3);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_y", out_y, 32'd8);
      check("single_zero", 32'(out_zero), 32'd0);
      check("single_wa", 32'(out_wa), 32'd3);
      check("single_count", 32'(count), 32'd1);
      out_ready = 1'b1; cyc(); out_ready = 1'b0;
      check("single_pop_count", 32'(count), 32'd0);

      push1(32'd0, 1'b1, 5'd5);
      check("zero_flag", 32'(out_zero), 32'd1);
      check("carry_flag", 32'(out_cout), 32'd1);
      out_ready = 1'b1; cyc(); out_ready = 1'b0;

      for (int v = 1; v <= 4; v++) push1(32'(v), 1'b0, 5'(v));
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'd4);
      set_in(1'b1, 32'd5, 1'b0, 5'd5);
      cyc();
      check("full_refuse_count", 32'(count), 32'd4);
      check("full_refuse_head", out_y, 32'd1);

      // Producer holds each value until accepted while the consumer pops continuously.
      expv = 1;
      out_ready = 1'b1;
      for (int v = 5; v <= 10; v++) begin
         set_in(1'b1, 32'(v), 1'b0, 5'(v));
         accepted = 1'b0;
         budget = 0;
         while (!accepted && budget < 10) begin
            accepted = in_ready;
            if (out_valid) begin
               check("order", out_y, 32'(expv));
               expv++;
            end
            cyc();
            budget++;
         end
         if (!accepted) check("push_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      budget = 0;
      while (out_valid && budget < 10) begin
         check("order", out_y, 32'(expv));
         expv++;
         cyc();
         budget++;
      end
      out_ready = 1'b0;
      check("order_total", 32'(expv), 32'd11);

      push1(32'd11, 1'b0, 5'd1);
      set_in(1'b1, 32'd12, 1'b0, 5'd1);
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("pp_count", 32'(count), 32'd1);
      check("pp_head", out_y, 32'd12);
      cyc();
      out_ready = 1'b0;
      out_ready = 1'b1; cyc(); out_ready = 1'b0;
      check("pp_empty", 32'(count), 32'd0);

      push1(32'd10, 1'b0, 5'd7);
      push1(32'd20, 1'b0, 5'd7);
      push1(32'd30, 1'b0, 5'd2);
      push1(32'd40, 1'b0, 5'd0);
      fwd_ra = 5'd7; #1;
      check("fwd7_hit", 32'(fwd_hit), 32'd1);
      check("fwd7_data", fwd_data, 32'd20);
      fwd_ra = 5'd2; #1;
      check("fwd2_data", fwd_data, 32'd30);
      fwd_ra = 5'd0; #1;
      check("fwd0_hit", 32'(fwd_hit), 32'd0);
      fwd_ra = 5'd9; #1;
      check("fwd9_hit", 32'(fwd_hit), 32'd0);
      check("fwd9_data", fwd_data, 32'd0);
      fwd_ra = 5'd7;

      out_ready = 1'b1; cyc(); out_ready = 1'b0;
      check("pre_flush_count", 32'(count), 32'd3);
      flush = 1'b1;
      set_in(1'b1, 32'd99, 1'b0, 5'd7);
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_fwd", 32'(fwd_hit), 32'd0);

      push1(32'd50, 1'b0, 5'd4);
      push1(32'd60, 1'b0, 5'd6);
      check("pre_reset_count", 32'(count), 32'd2);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      check("midreset_count", 32'(count), 32'd0);
      check("midreset_in_ready", 32'(in_ready), 32'd1);

      out_ready = 1'b1; cyc(); out_ready = 1'b0;
      check("empty_pop_ignored", 32'(count), 32'd0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
